// File: rtl/apb_master_if.sv
// Bundle of the CPU request/response signals and the APB bus signals seen by
// apb_master. The master modport is the bridge's view. The slave modport is
// the view of everything around it: the core and the five peripherals.
interface apb_master_if;
   // CPU side
   logic        transfer;
   logic        write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   // APB side
   logic [31:0] PADDR;
   logic        PWRITE;
   logic        PENABLE;
   logic [31:0] PWDATA;
   logic        PSEL0;
   logic        PSEL1;
   logic        PSEL2;
   logic        PSEL3;
   logic        PSEL4;
   logic [31:0] PRDATA0;
   logic [31:0] PRDATA1;
   logic [31:0] PRDATA2;
   logic [31:0] PRDATA3;
   logic [31:0] PRDATA4;
   logic        PREADY0;
   logic        PREADY1;
   logic        PREADY2;
   logic        PREADY3;
   logic        PREADY4;

   modport master (
      input  transfer, write, addr, wdata,
      input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
      input  PREADY0, PREADY1, PREADY2, PREADY3, PREADY4,
      output rdata, ready, err,
      output PADDR, PWRITE, PENABLE, PWDATA,
      output PSEL0, PSEL1, PSEL2, PSEL3, PSEL4
   );

   modport slave (
      output transfer, write, addr, wdata,
      output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
      output PREADY0, PREADY1, PREADY2, PREADY3, PREADY4,
      input  rdata, ready, err,
      input  PADDR, PWRITE, PENABLE, PWDATA,
      input  PSEL0, PSEL1, PSEL2, PSEL3, PSEL4
   );
endinterface

// File: rtl/apb_master.sv
// APB3 bridge: turns single-cycle CPU load/store strobes into IDLE/SETUP/ACCESS
// transactions on five APB slaves (RAM, GPO, GPI, GPIO, UART). It returns a
// one-cycle ready pulse with read data and an error flag.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase timeout that aborts
// with err=1 and rdata=32'hDEAD_BEEF after TIMEOUT_CYCLES cycles.
module apb_master #(
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter int          SLOT_SHIFT     = 12,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic         PCLK,
   input  logic         PRESET,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   localparam logic [31:0] ABORT_DATA_C = 32'hDEAD_BEEF;

   // Reject a timeout limit that does not fit the 8-bit ACCESS counter.
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
   end

   state_e      state_q, state_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        pwrite_q, pwrite_d;
   logic [4:0]  psel_q, psel_d;
   logic        penable_q, penable_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;

   logic [31:0] offset_s;
   logic [31:0] slot_s;
   logic        mapped_s;
   logic [4:0]  psel_dec_s;
   logic [4:0]  pready_vec_s;
   logic        pready_sel_s;
   logic [31:0] prdata_sel_s;
   logic        unmapped_s;
   logic        done_s;
   logic        timeout_s;

   // Slot decode of the incoming CPU address. Addresses below the window wrap
   // to a huge offset, but the explicit lower-bound test keeps them unmapped.
   assign offset_s = bus.addr - BASE_ADDR;
   assign slot_s   = offset_s >> SLOT_SHIFT;
   assign mapped_s = (bus.addr >= BASE_ADDR) && (slot_s < 32'd5);

   // One-hot select pattern for the request being accepted in IDLE.
   always_comb begin
      psel_dec_s = 5'b0_0000;
      if (mapped_s) begin
         case (slot_s[2:0])
            3'd0:    psel_dec_s = 5'b0_0001;
            3'd1:    psel_dec_s = 5'b0_0010;
            3'd2:    psel_dec_s = 5'b0_0100;
            3'd3:    psel_dec_s = 5'b0_1000;
            3'd4:    psel_dec_s = 5'b1_0000;
            default: psel_dec_s = 5'b0_0000;
         endcase
      end else begin
         psel_dec_s = 5'b0_0000;
      end
   end

   // The latched PSEL vector steers both the PREADY and PRDATA muxes. An
   // all-zero vector marks an unmapped transfer that completes on its own.
   assign pready_vec_s = {bus.PREADY4, bus.PREADY3, bus.PREADY2, bus.PREADY1, bus.PREADY0};
   assign pready_sel_s = |(psel_q & pready_vec_s);
   assign unmapped_s   = (psel_q == 5'b0_0000);
   assign done_s       = (state_q == ST_ACCESS) && (pready_sel_s || unmapped_s);

   // Read-data mux of the currently selected slave.
   always_comb begin
      prdata_sel_s = 32'h0000_0000;
      case (psel_q)
         5'b0_0001: prdata_sel_s = bus.PRDATA0;
         5'b0_0010: prdata_sel_s = bus.PRDATA1;
         5'b0_0100: prdata_sel_s = bus.PRDATA2;
         5'b0_1000: prdata_sel_s = bus.PRDATA3;
         5'b1_0000: prdata_sel_s = bus.PRDATA4;
         default:   prdata_sel_s = 32'h0000_0000;
      endcase
   end

`ifdef APB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST_C = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   // ACCESS-cycle counter: zero in the first ACCESS cycle, +1 per wait cycle.
   always_comb begin
      cnt_d = cnt_q;
      case (state_q)
         ST_SETUP:  cnt_d = 8'd0;
         ST_ACCESS: cnt_d = cnt_q + 8'd1;
         default:   cnt_d = cnt_q;
      endcase
   end

   // ACCESS-cycle counter register.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Abort in the TIMEOUT_CYCLES-th ACCESS cycle if the slave is still busy.
   assign timeout_s = (state_q == ST_ACCESS) && !done_s && (cnt_q == TIMEOUT_LAST_C);
`else
   assign timeout_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: SETUP always lasts one cycle. ACCESS lasts until the
   // slave is ready or the timeout fires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.transfer) begin
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (done_s || timeout_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs. PSEL is set on the IDLE->SETUP
   // edge so that it is already high during SETUP.
   always_comb begin
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      ready_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.transfer) begin
               paddr_d   = bus.addr;
               pwdata_d  = bus.wdata;
               pwrite_d  = bus.write;
               psel_d    = psel_dec_s;
               penable_d = 1'b0;
            end else begin
               psel_d    = 5'b0_0000;
               penable_d = 1'b0;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (done_s) begin
               ready_d   = 1'b1;
               psel_d    = 5'b0_0000;
               penable_d = 1'b0;
               if (unmapped_s) begin
                  rdata_d = 32'h0000_0000;
                  err_d   = 1'b1;
               end else if (pwrite_q) begin
                  rdata_d = 32'h0000_0000;
                  err_d   = 1'b0;
               end else begin
                  rdata_d = prdata_sel_s;
                  err_d   = 1'b0;
               end
            end else if (timeout_s) begin
               ready_d   = 1'b1;
               psel_d    = 5'b0_0000;
               penable_d = 1'b0;
               rdata_d   = ABORT_DATA_C;
               err_d     = 1'b1;
            end else begin
               penable_d = 1'b1;
            end
         end
         default: begin
            psel_d    = 5'b0_0000;
            penable_d = 1'b0;
         end
      endcase
   end

   // Output registers: every bus and CPU-facing output comes straight from a flop.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         paddr_q   <= 32'h0000_0000;
         pwdata_q  <= 32'h0000_0000;
         pwrite_q  <= 1'b0;
         psel_q    <= 5'b0_0000;
         penable_q <= 1'b0;
         rdata_q   <= 32'h0000_0000;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   assign bus.PADDR   = paddr_q;
   assign bus.PWDATA  = pwdata_q;
   assign bus.PWRITE  = pwrite_q;
   assign bus.PENABLE = penable_q;
   assign bus.PSEL0   = psel_q[0];
   assign bus.PSEL1   = psel_q[1];
   assign bus.PSEL2   = psel_q[2];
   assign bus.PSEL3   = psel_q[3];
   assign bus.PSEL4   = psel_q[4];
   assign bus.rdata   = rdata_q;
   assign bus.ready   = ready_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed cases plus randomized
// transfers. Expected values come from an address-arithmetic model of the bridge.
module tb_apb_master;
   localparam logic [31:0] BASE       = 32'h1000_0000;
   localparam int unsigned SLOT_BYTES = 4096;
`ifdef APB_TIMEOUT_EN
   localparam int TMO = 4;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] prd [5];
   logic [4:0]  prdy;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_rdata;
   logic        exp_err;

   apb_master_if bus_if ();

   apb_master #(
      .BASE_ADDR      (BASE),
      .SLOT_SHIFT     (12),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .PCLK   (clk),
      .PRESET (rst),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   assign bus_if.PRDATA0 = prd[0];
   assign bus_if.PRDATA1 = prd[1];
   assign bus_if.PRDATA2 = prd[2];
   assign bus_if.PRDATA3 = prd[3];
   assign bus_if.PRDATA4 = prd[4];
   assign bus_if.PREADY0 = prdy[0];
   assign bus_if.PREADY1 = prdy[1];
   assign bus_if.PREADY2 = prdy[2];
   assign bus_if.PREADY3 = prdy[3];
   assign bus_if.PREADY4 = prdy[4];

   wire [4:0] psel_w = {bus_if.PSEL4, bus_if.PSEL3, bus_if.PSEL2, bus_if.PSEL1, bus_if.PSEL0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: slave index of an address, -1 when outside the five 4 KiB windows.
   function automatic int slot_of(input logic [31:0] a);
      int unsigned off;
      if (a < BASE) return -1;
      off = a - BASE;
      if ((off / SLOT_BYTES) > 4) return -1;
      return int'(off / SLOT_BYTES);
   endfunction

   task automatic randomize_slaves();
      for (int i = 0; i < 5; i++) prd[i] = $urandom;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_paddr"},   bus_if.PADDR, 32'h0);
      chk({tag, "_pwdata"},  bus_if.PWDATA, 32'h0);
      chk({tag, "_pwrite"},  32'(bus_if.PWRITE), 32'h0);
      chk({tag, "_penable"}, 32'(bus_if.PENABLE), 32'h0);
      chk({tag, "_psel"},    32'(psel_w), 32'h0);
      chk({tag, "_rdata"},   bus_if.rdata, 32'h0);
      chk({tag, "_ready"},   32'(bus_if.ready), 32'h0);
      chk({tag, "_err"},     32'(bus_if.err), 32'h0);
   endtask

   // Present a request at the current falling edge.
   task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] wd);
      bus_if.transfer = 1'b1;
      bus_if.write    = wr;
      bus_if.addr     = a;
      bus_if.wdata    = wd;
   endtask

   // Follow one transfer from SETUP to its ready cycle; w = slave wait cycles.
   // Returns at the falling edge inside the ready cycle.
   task automatic check_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input int w);
      int         s;
      int         acc_len;
      logic [4:0] ps;
      s  = slot_of(a);
      ps = (s < 0) ? 5'b0_0000 : 5'(32'd1 << s);
      if (s < 0) begin
         acc_len   = 1;
         exp_rdata = 32'h0;
         exp_err   = 1'b1;
      end else begin
         acc_len   = w + 1;
         exp_rdata = wr ? 32'h0 : prd[s];
         exp_err   = 1'b0;
`ifdef APB_TIMEOUT_EN
         if (w >= TMO) begin
            acc_len   = TMO;
            exp_rdata = 32'hDEAD_BEEF;
            exp_err   = 1'b1;
         end
`endif
      end
      @(negedge clk);
      // SETUP: requests arriving now must be ignored
      bus_if.transfer = 1'($urandom);
      bus_if.write    = 1'($urandom);
      bus_if.addr     = $urandom;
      bus_if.wdata    = $urandom;
      prdy = 5'($urandom);
      if (s >= 0) prdy[s] = 1'b0;
      chk("setup_psel",    32'(psel_w), 32'(ps));
      chk("setup_penable", 32'(bus_if.PENABLE), 32'h0);
      chk("setup_ready",   32'(bus_if.ready), 32'h0);
      chk("setup_paddr",   bus_if.PADDR, a);
      chk("setup_pwdata",  bus_if.PWDATA, wd);
      chk("setup_pwrite",  32'(bus_if.PWRITE), 32'(wr));
      for (int j = 1; j <= acc_len; j++) begin
         @(negedge clk);
         bus_if.transfer = 1'($urandom);
         bus_if.addr     = $urandom;
         prdy = 5'($urandom);
         if (s >= 0) prdy[s] = (j == w + 1);
         chk("access_psel",    32'(psel_w), 32'(ps));
         chk("access_penable", 32'(bus_if.PENABLE), 32'h1);
         chk("access_ready",   32'(bus_if.ready), 32'h0);
         chk("access_paddr",   bus_if.PADDR, a);
      end
      @(negedge clk);
      bus_if.transfer = 1'b0;
      prdy = 5'($urandom);
      chk("done_ready",   32'(bus_if.ready), 32'h1);
      chk("done_err",     32'(bus_if.err), 32'(exp_err));
      chk("done_rdata",   bus_if.rdata, exp_rdata);
      chk("done_psel",    32'(psel_w), 32'h0);
      chk("done_penable", 32'(bus_if.PENABLE), 32'h0);
   endtask

   // One idle cycle after a completion: ready drops, rdata/err hold.
   task automatic idle_step();
      bus_if.transfer = 1'b0;
      @(negedge clk);
      chk("idle_ready",   32'(bus_if.ready), 32'h0);
      chk("idle_rdata",   bus_if.rdata, exp_rdata);
      chk("idle_err",     32'(bus_if.err), 32'(exp_err));
      chk("idle_psel",    32'(psel_w), 32'h0);
      chk("idle_penable", 32'(bus_if.PENABLE), 32'h0);
   endtask

   task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int w);
      start_req(wr, a, wd);
      check_xfer(wr, a, wd, w);
      idle_step();
   endtask

   initial begin
      logic [31:0] ra;
      logic        rw;
      logic [31:0] rwd;
      int          mode;
      bus_if.transfer = 1'b0;
      bus_if.write    = 1'b0;
      bus_if.addr     = 32'h0;
      bus_if.wdata    = 32'h0;
      prdy            = 5'b0_0000;
      randomize_slaves();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", 32'(bus_if.ready), 32'h0);

      // store to GPO, zero wait
      do_xfer(1'b1, 32'h1000_1000, 32'h0000_000F, 0);
      // load from GPI with three wait cycles
      prd[2] = 32'h0000_000A;
      do_xfer(1'b0, 32'h1000_2000, 32'h0, 3);
      // unmapped load far above the window
      do_xfer(1'b0, 32'h2000_0000, 32'h0, 0);
      // back-to-back stores, second request in the ready cycle
      start_req(1'b1, 32'h1000_1004, 32'h0000_000F);
      check_xfer(1'b1, 32'h1000_1004, 32'h0000_000F, 0);
      start_req(1'b1, 32'h1000_1004, 32'h0000_0000);
      check_xfer(1'b1, 32'h1000_1004, 32'h0000_0000, 0);
      idle_step();
      // window boundaries
      do_xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 1);
      randomize_slaves();
      do_xfer(1'b0, 32'h1000_0000, 32'h0, 1);
      do_xfer(1'b0, 32'h1000_4FFC, 32'h0, 2);
      do_xfer(1'b1, 32'h1000_5000, 32'h1234_5678, 0);

      // reset while stalled in ACCESS
      start_req(1'b0, 32'h1000_3000, 32'h0);
      prdy = 5'b0_0000;
      @(negedge clk);
      bus_if.transfer = 1'b0;
      @(negedge clk);
      chk("stall_penable", 32'(bus_if.PENABLE), 32'h1);
      #2 rst = 1'b1;
      #1 check_all_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_ready", 32'(bus_if.ready), 32'h0);
         chk("abort_no_psel",  32'(psel_w), 32'h0);
      end
      do_xfer(1'b1, 32'h1000_1000, 32'h0000_005A, 1);

`ifdef APB_TIMEOUT_EN
      // slave never answers
      do_xfer(1'b0, 32'h1000_4000, 32'h0, 20);
      // slave answers in the last allowed ACCESS cycle
      randomize_slaves();
      do_xfer(1'b0, 32'h1000_4000, 32'h0, TMO - 1);
`endif

      // randomized traffic, randomly back-to-back or separated by an idle cycle
      for (int i = 0; i < 60; i++) begin
         mode = $urandom_range(0, 9);
         if (mode < 7) begin
            ra = BASE + 32'($urandom_range(0, 4)) * SLOT_BYTES + 32'($urandom_range(0, 1023)) * 32'd4;
         end else if (mode == 7) begin
            ra = BASE + 32'($urandom_range(5, 15)) * SLOT_BYTES;
         end else if (mode == 8) begin
            ra = 32'($urandom_range(0, 32'h0FFF_FFFF));
         end else begin
            ra = 32'h8000_0000 | 32'($urandom);
         end
         rw  = 1'($urandom);
         rwd = $urandom;
         randomize_slaves();
         start_req(rw, ra, rwd);
         check_xfer(rw, ra, rwd, $urandom_range(0, 5));
         if ($urandom_range(0, 1) == 1) idle_step();
      end
      idle_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
